// File: rtl/tuser_out_fsm_pkg.sv
// Shared definitions for the egress tuple/stream merger.
package tuser_out_fsm_pkg;

  // Default widths of the SDNet egress stream and tuple.
  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_KEEP_WIDTH  = 32;
  localparam int DEF_TUSER_WIDTH = 128;
  localparam int DEF_TUPLE_DEPTH = 4;

  // Merger FSM encodings; 2'b10 and 2'b11 are illegal and recover to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BODY = 2'b01;

endpackage

// File: rtl/tuser_out_fsm_tuple_fifo.sv
// Small synchronous FIFO holding per-packet tuples until their first beat.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tuple_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tuser_out_fsm.sv
// Egress merger: rejoins the SDNet packet stream with its per-packet tuple,
// placing the tuple on tout_btuser of each packet's first beat.
//
// Handshakes: a beat moves on a port when valid and ready are both high at a
// rising clock edge. Valid, once high, holds with stable payload until that
// edge; ready may change freely. The tuple input has no ready: a tuple
// arriving while the FIFO is full (and not popping) is dropped.
module tuser_out_fsm
  import tuser_out_fsm_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH  = DEF_KEEP_WIDTH,
  parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
  parameter int TUPLE_DEPTH = DEF_TUPLE_DEPTH
) (
  input  logic                   tout_aclk,
  input  logic                   tout_arst,
  input  logic                   tout_avalid,
  output logic                   tout_aready,
  input  logic [DATA_WIDTH-1:0]  tout_adata,
  input  logic [KEEP_WIDTH-1:0]  tout_akeep,
  input  logic                   tout_atlast,
  input  logic                   tout_valid,
  input  logic [TUSER_WIDTH-1:0] tout_data,
  output logic                   tout_bvalid,
  input  logic                   tout_bready,
  output logic [DATA_WIDTH-1:0]  tout_bdata,
  output logic [KEEP_WIDTH-1:0]  tout_bkeep,
  output logic                   tout_btlast,
  output logic [TUSER_WIDTH-1:0] tout_btuser,
  output logic [31:0]            pkt_cnt,
  output logic                   tuple_ovf,
  output logic [1:0]             dbg_state
);

  logic [1:0]             state_q, state_d;
  logic                   bvalid_q, bvalid_d;
  logic [DATA_WIDTH-1:0]  bdata_q, bdata_d;
  logic [KEEP_WIDTH-1:0]  bkeep_q, bkeep_d;
  logic                   btlast_q, btlast_d;
  logic [TUSER_WIDTH-1:0] btuser_q, btuser_d;
  logic [31:0]            pkt_cnt_q, pkt_cnt_d;
  logic                   ovf_q, ovf_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [TUSER_WIDTH-1:0] fifo_head;
  logic                   go;
  logic                   load;

  // First beats wait for a queued tuple; body beats always may proceed.
  always_comb begin
    case (state_q)
      ST_IDLE: go = ~fifo_empty;
      ST_BODY: go = 1'b1;
      default: go = 1'b0;
    endcase
  end

  assign tout_aready = go & (~bvalid_q | tout_bready);
  assign load        = tout_avalid & tout_aready;
  assign fifo_pop    = load & (state_q == ST_IDLE);

  tuple_fifo #(
    .WIDTH (TUSER_WIDTH),
    .DEPTH (TUPLE_DEPTH)
  ) u_tuple_fifo (
    .clk   (tout_aclk),
    .rst   (tout_arst),
    .push  (tout_valid),
    .pop   (fifo_pop),
    .wdata (tout_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Packet framing: IDLE waits for a first beat, BODY runs until tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load && !tout_atlast) state_d = ST_BODY;
      ST_BODY: if (load &&  tout_atlast) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: capture on load, release once the downstream takes it.
  always_comb begin
    bvalid_d = bvalid_q;
    bdata_d  = bdata_q;
    bkeep_d  = bkeep_q;
    btlast_d = btlast_q;
    btuser_d = btuser_q;
    if (load) begin
      bvalid_d = 1'b1;
      bdata_d  = tout_adata;
      bkeep_d  = tout_akeep;
      btlast_d = tout_atlast;
      btuser_d = (state_q == ST_IDLE) ? fifo_head : '0;
    end else if (tout_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Packet counter and sticky tuple-drop flag.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (bvalid_q && tout_bready && btlast_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
    ovf_d = ovf_q | (tout_valid & fifo_full & ~fifo_pop);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge tout_aclk or posedge tout_arst) begin
    if (tout_arst) begin
      state_q   <= ST_IDLE;
      bvalid_q  <= 1'b0;
      bdata_q   <= '0;
      bkeep_q   <= '0;
      btlast_q  <= 1'b0;
      btuser_q  <= '0;
      pkt_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bvalid_q  <= bvalid_d;
      bdata_q   <= bdata_d;
      bkeep_q   <= bkeep_d;
      btlast_q  <= btlast_d;
      btuser_q  <= btuser_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tout_bvalid = bvalid_q;
  assign tout_bdata  = bdata_q;
  assign tout_bkeep  = bkeep_q;
  assign tout_btlast = btlast_q;
  assign tout_btuser = btuser_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign tuple_ovf   = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/tuser_out_fsm.md
# tuser_out_fsm

Egress-side merger for the SDNet pipeline. It takes the packet stream and the per-packet output tuple that SDNet emits separately, and rejoins them into a single 256-bit AXI4-Stream. The tuple is placed on `tout_btuser` of the first beat of each packet, so metadata returns to the sideband it was extracted from at ingress. It sits between the SDNet engine output and the datapath output queues.

## Interface
Parameters:
- `DATA_WIDTH`, 256, stream data width.
- `KEEP_WIDTH`, 32, byte-enable width (`DATA_WIDTH/8`).
- `TUSER_WIDTH`, 128, tuple / tuser width.
- `TUPLE_DEPTH`, 4, tuple FIFO entries (power of 2, ≥2).

Ports:
- `tout_aclk`, in, 1, clock.
- `tout_arst`, in, 1, reset. Asynchronous, active-high.
- `tout_avalid`, in, 1, SDNet stream valid.
- `tout_aready`, out, 1, SDNet stream ready.
- `tout_adata`, in, DATA_WIDTH, SDNet stream data.
- `tout_akeep`, in, KEEP_WIDTH, SDNet stream keep.
- `tout_atlast`, in, 1, SDNet stream last.
- `tout_valid`, in, 1, tuple valid. One-cycle pulse per packet, no backpressure.
- `tout_data`, in, TUSER_WIDTH, tuple value.
- `tout_bvalid`, out, 1, output stream valid.
- `tout_bready`, in, 1, output stream ready.
- `tout_bdata`, out, DATA_WIDTH, output stream data.
- `tout_bkeep`, out, KEEP_WIDTH, output stream keep.
- `tout_btlast`, out, 1, output stream last.
- `tout_btuser`, out, TUSER_WIDTH, output tuser. Tuple on first beat, 0 on all other beats.
- `pkt_cnt`, out, 32, packets emitted.
- `tuple_ovf`, out, 1, sticky tuple-drop flag.
- `dbg_state`, out, 2, FSM state.

## Operation
- **Tuple FIFO.**
  - Writes `tout_data` when `tout_valid` is high and the FIFO is not full.
  - Write while full: tuple discarded, `tuple_ovf` set. `tuple_ovf` clears only on reset.
  - Pops one entry when the first beat of a packet is accepted on input.
- **Output register.** `load = tout_avalid & tout_aready`. `tout_aready = go & (~tout_bvalid | tout_bready)`, where:
  - IDLE: `go = ~fifo_empty`.
  - BODY: `go = 1`.
- **FSM.**
  - IDLE (00), on load:
    - `tout_btuser` ← FIFO head, pop FIFO.
    - If `tout_atlast` = 1 (single-beat packet): stay in IDLE.
    - Otherwise: go to BODY.
  - BODY (01), on load:
    - `tout_btuser` ← 0.
    - If `tout_atlast` = 1: go to IDLE.
  - Encodings 10 and 11 are illegal; return to IDLE.
- **Output beat.**
  - On load: `tout_bdata`/`tout_bkeep`/`tout_btlast` ← input fields, `tout_bvalid` ← 1.
  - No load and `tout_bready` = 1: `tout_bvalid` ← 0.
- **Packet counter.** `pkt_cnt` increments on each output handshake with `tout_btlast` = 1. It wraps from 0xFFFFFFFF to 0.
- **Reset values.** All outputs 0 (`tout_aready`, `tout_bvalid`, `tout_bdata`, `tout_bkeep`, `tout_btlast`, `tout_btuser`, `pkt_cnt`, `tuple_ovf`). `dbg_state` = IDLE. FIFO empty.

## Timing
- Throughput: one beat per cycle when `tout_bready` is held high and a tuple is queued.
- Latency: 1 cycle from input handshake to `tout_bvalid`.
- FIFO write-to-read latency: 1 cycle. A tuple pulsed in the same cycle as the first beat stalls that beat for exactly 1 cycle (`tout_aready` = 0).
- Tuples may arrive any number of cycles before the first beat. The first beat is held (`tout_aready` = 0) until a tuple is present.
- Simultaneous FIFO push and pop on a full FIFO: the pop frees the slot, the push succeeds, no overflow.
- Output stall (`tout_bvalid` = 1, `tout_bready` = 0): all outputs hold and `tout_aready` = 0.
- Reset asserted mid-packet: everything returns to its reset value immediately. Any partial packet is discarded.

## Structure
- Shared package holds the state encodings (`ST_IDLE`, `ST_BODY`) and the default widths 256/32/128.
- One sub-module: `tuple_fifo`, a synchronous FIFO with `full`/`empty` flags and pointers one bit wider than `log2(TUPLE_DEPTH)`.

## Test plan
- **Single-beat packet.** Tuple `0xA5..A5` one cycle before a beat with `tlast=1`, `keep=0xFFFFFFFF`, `bready=1` -> one output beat with `btuser=0xA5..A5`, `btlast=1`; `pkt_cnt=1`.
- **Four-beat packet.** Tuple 0x1 -> `btuser` is 0x1 on beat 0 and 0 on beats 1–3; `btlast` only on beat 3; data unchanged and in order.
- **Late tuple.** First beat valid for 5 cycles with no tuple -> `tout_aready`=0 and no output. Tuple arrives at cycle 5 -> beat accepted at cycle 6, output at cycle 7.
- **Backpressure.** `bready` toggling 1/0 every cycle over a 3-beat packet -> no beat lost or duplicated, outputs stable while stalled.
- **Overflow.** 5 tuples with no packets (depth 4) -> `tuple_ovf`=1. Four subsequent packets receive tuples 1–4 in order.
- **Reset mid-packet.** Assert `tout_arst` on beat 2 of 4 -> all outputs 0 asynchronously. The next packet after release is handled normally with `pkt_cnt` restarting at 0.
